mux_rr_arb: RTL and testbench
=============================

MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum accepted transfers per grant tenure; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  4  request per channel; bit i = channel i.
REQ-005 Port: in0, in1, in2, in3  input  2 each  channel data.
REQ-006 Port: ack  input  1  downstream accepts current beat.
REQ-007 Port: gnt  output  4  one-hot grant, registered.
REQ-008 Port: select  output  2  index of granted channel, registered.
REQ-009 Port: valid  output  1  out carries a beat; registered.
REQ-010 Port: out  output  2  granted channel data; 2'b00 when valid=0.

Function
REQ-011 FSM states: IDLE, GRANT; state change only on the clk edge.
REQ-012 IDLE, req=0: stay IDLE; gnt=0, valid=0.
REQ-013 IDLE, req!=0: next edge -> GRANT, winner chosen round-robin, gnt=one-hot(winner), select=winner, valid=1, beat_cnt=0.
REQ-014 Round-robin search order: ptr+1, ptr+2, ptr+3, ptr (mod 4); first set req bit wins.
REQ-015 Request-to-grant latency is exactly 1 cycle from IDLE.
REQ-016 In GRANT: out = in[select] combinationally from the registered select; gnt, select stable for the whole tenure.
REQ-017 A transfer occurs on any edge with valid=1 and ack=1; beat_cnt increments by 1 per transfer, width 4 bits, never wraps.
REQ-018 Release when req[select]=0 at an edge: -> IDLE, regardless of ack; a coincident ack still counts as that cycle's transfer.
REQ-019 Release when a transfer occurs with beat_cnt=HOLD_MAX-1 (limit feature compiled in): -> IDLE.
REQ-020 On every release ptr <= select; gnt=0, valid=0 in the following IDLE cycle (one-cycle bubble between tenures).
REQ-021 ack while valid=0 is ignored.
REQ-022 Requests arriving or dropping for non-granted channels during GRANT have no effect until the next IDLE.
REQ-023 gnt SHALL never have more than one bit set; gnt=0 iff valid=0.

Reset
REQ-024 rst_n=0 at an edge: state=IDLE, gnt=4'b0000, select=2'b00, valid=0, out=2'b00, beat_cnt=0, ptr=2'b11 (channel 0 first).
REQ-025 Reset mid-tenure aborts immediately; no transfer is counted on the reset edge.
REQ-026 First arbitration is possible on the first edge with rst_n=1.

Configuration
REQ-027 Macro MUX_RR_ARB_HOLD_LIMIT_EN: defined -> REQ-019 active, tenure capped at HOLD_MAX transfers.
REQ-028 Without MUX_RR_ARB_HOLD_LIMIT_EN: holder keeps grant until its req drops; beat_cnt and HOLD_MAX logic absent; HOLD_MAX ignored.

Structure
REQ-029 Package mux_rr_arb_pkg: state enum (IDLE, GRANT), NUM_CH=4, IDX_W=2, DATA_W=2, CNT_W=4, HOLD_MAX default.
REQ-030 Sub-module rr_pick: combinational; inputs req[3:0], ptr[1:0]; outputs any, winner[1:0].

Verification
REQ-031 Reset then req=4'b0001 -> next cycle gnt=0001, select=00, valid=1, out=in0.
REQ-032 req=4'b1111 held, ack=1, limit on, HOLD_MAX=4 -> grants rotate 0,1,2,3,0; each tenure 4 transfers, one bubble cycle between tenures.
REQ-033 Grant to ch2, req[2] drops with ack=0 -> next cycle valid=0, gnt=0; ptr=2, so with req=4'b0101 next winner is ch0.
REQ-034 Limit off, req=4'b0011, ack=1 for 20 cycles -> ch0 holds grant all 20 cycles.
REQ-035 Grant to ch1 with beat_cnt=2, rst_n=0 one cycle -> gnt=0, valid=0, out=00; after release with req=4'b0010 ch1 regranted after 1 cycle.
REQ-036 ack=0 throughout with req[3]=1, limit on -> ch3 holds indefinitely, beat_cnt stays 0, out tracks in3 changes same cycle.

Source files
------------

// File: rtl/mux_rr_arb_pkg.sv
// rtl/mux_rr_arb_pkg.sv - shared types, widths and helpers for the round-robin channel mux
package mux_rr_arb_pkg;

    localparam int NUM_CH       = 4;
    localparam int IDX_W        = 2;
    localparam int DATA_W       = 2;
    localparam int CNT_W        = 4;
    localparam int HOLD_MAX_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_rr_arb_rr_pick.sv
// rtl/mux_rr_arb_rr_pick.sv - combinational round-robin winner search starting after ptr
module rr_pick
    import mux_rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              any,
    output logic [IDX_W-1:0]  winner
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        any    = |req;
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        // k = NUM_CH wraps back onto ptr itself, so the last holder is checked last
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// rtl/mux_rr_arb.sv - 4-channel round-robin arbitrated mux with one-cycle bubble between tenures
// Optional macro MUX_RR_ARB_HOLD_LIMIT_EN caps each tenure at HOLD_MAX transfers.
module mux_rr_arb
    import mux_rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic [DATA_W-1:0]   in0,
    input  logic [DATA_W-1:0]   in1,
    input  logic [DATA_W-1:0]   in2,
    input  logic [DATA_W-1:0]   in3,
    input  logic                ack,
    output logic [NUM_CH-1:0]   gnt,
    output logic [IDX_W-1:0]    select,
    output logic                valid,
    output logic [DATA_W-1:0]   out
);

    state_t              r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]    r_select, w_select_nxt;
    logic                r_valid, w_valid_nxt;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
    logic                w_any;
    logic [IDX_W-1:0]    w_winner;
    logic                w_xfer;
    logic                w_limit_hit;
    logic [DATA_W-1:0]   w_in [NUM_CH];

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;
    assign w_xfer  = r_valid && ack;

`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    assign w_limit_hit = w_xfer && (r_beat_cnt == CNT_W'(HOLD_MAX - 1));
`else
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_MAX != 0);
    assign w_limit_hit   = 1'b0;
`endif

    rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .any    (w_any),
        .winner (w_winner)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_select_nxt = r_select;
        w_valid_nxt  = r_valid;
        w_ptr_nxt    = r_ptr;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
        w_beat_cnt_nxt = r_beat_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = onehot(w_winner);
                    w_select_nxt = w_winner;
                    w_valid_nxt  = 1'b1;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
                    w_beat_cnt_nxt = '0;
`endif
                end
            end
            GRANT: begin
                // Losing the request wins over a coincident ack; that ack is still the last beat.
                if (!req[r_select] || w_limit_hit) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_select;
                end
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
                else if (w_xfer && (r_beat_cnt != '1)) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_select <= '0;
            r_valid  <= 1'b0;
            r_ptr    <= '1;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
            r_beat_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_select <= w_select_nxt;
            r_valid  <= w_valid_nxt;
            r_ptr    <= w_ptr_nxt;
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
            r_beat_cnt <= w_beat_cnt_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign select = r_select;
    assign valid  = r_valid;
    assign out    = r_valid ? w_in[r_select] : '0;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb/tb_mux_rr_arb.sv - scoreboard bench for mux_rr_arb with directed per-cycle expectations
module tb_mux_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] in0, in1, in2, in3;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       valid;
    logic [1:0] out;

    always #5 clk = ~clk;

    mux_rr_arb dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .in0    (in0),
        .in1    (in1),
        .in2    (in2),
        .in3    (in3),
        .ack    (ack),
        .gnt    (gnt),
        .select (select),
        .valid  (valid),
        .out    (out)
    );

    typedef struct {
        string      name;
        logic [3:0] gnt;
        int         sel;
        logic       valid;
        logic [1:0] out;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Drive this cycle's inputs and queue the outputs expected in this same cycle,
    // which result from the inputs driven by the previous step. sel < 0 = don't care.
    task automatic step(input string name, input logic r, input logic [3:0] rq,
                        input logic a, input logic ev, input int es,
                        input logic [1:0] d3 = 2'b10);
        exp_t       e;
        logic [1:0] d [4];
        @(posedge clk);
        #2;
        rst_n = r;
        req   = rq;
        ack   = a;
        in3   = d3;
        d[0] = in0; d[1] = in1; d[2] = in2; d[3] = in3;
        e.name  = name;
        e.valid = ev;
        e.sel   = es;
        e.gnt   = ev ? (4'b0001 << es) : 4'b0000;
        e.out   = ev ? d[es] : 2'b00;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (gnt !== e.gnt || valid !== e.valid || out !== e.out ||
                    (e.sel >= 0 && select !== e.sel[1:0])) begin
                    errors++;
                    $display("FAIL %s: got gnt=%b select=%0d valid=%b out=%b, want gnt=%b select=%0d valid=%b out=%b",
                             e.name, gnt, select, valid, out, e.gnt, e.sel, e.valid, e.out);
                end
                checks++;
                if ($countones(gnt) > 1 || ((gnt == 4'b0000) != (valid == 1'b0))) begin
                    errors++;
                    $display("FAIL %s invariant: got gnt=%b valid=%b, want one-hot gnt iff valid", e.name, gnt, valid);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, want finish");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0; req = 4'b0000; ack = 1'b0;
        in0 = 2'b01; in1 = 2'b10; in2 = 2'b11; in3 = 2'b10;

        step("reset", 0, 4'b0000, 0, 0, 0);
        // first request after reset: ch0, one-cycle latency
        step("post_reset_idle", 1, 4'b0001, 0, 0, 0);
        step("first_grant_ch0", 1, 4'b0001, 0, 1, 0);
        step("ch0_hold", 1, 4'b0000, 0, 1, 0);
        step("ch0_released", 1, 4'b0000, 0, 0, -1);
        // ch2 drops with ack=0, ptr moves to 2, next winner of 0101 is ch0
        step("idle_before_ch2", 1, 4'b0100, 0, 0, -1);
        step("grant_ch2", 1, 4'b0100, 0, 1, 2);
        step("ch2_drop_cycle", 1, 4'b0000, 0, 1, 2);
        step("ch2_released", 1, 4'b0101, 0, 0, -1);
        step("rr_after_ch2_is_ch0", 1, 4'b0101, 0, 1, 0);
        step("ch0_hold2", 1, 4'b0000, 0, 1, 0);
        step("ch0_released2", 1, 4'b0000, 0, 0, -1);
        // ch1 mid-tenure reset, ack while idle ignored
        step("ack_in_idle", 1, 4'b0010, 1, 0, -1);
        step("grant_ch1_b0", 1, 4'b0010, 1, 1, 1);
        step("ch1_b1", 1, 4'b0010, 1, 1, 1);
        step("ch1_b2_reset", 0, 4'b0010, 1, 1, 1);
        step("after_mid_reset", 1, 4'b0010, 0, 0, 0);
        step("ch1_regrant", 1, 4'b0010, 0, 1, 1);
        step("ch1_hold", 1, 4'b0000, 0, 1, 1);
        step("ch1_released", 1, 4'b0000, 0, 0, -1);
        // ch3 with ack=0 holds indefinitely, out follows in3 in the same cycle
        step("idle_before_ch3", 1, 4'b1000, 0, 0, -1);
        for (int i = 0; i < 20; i++)
            step("ch3_hold_noack", 1, 4'b1000, 0, 1, 3, 2'(i));
        step("ch3_drop_cycle", 1, 4'b0000, 0, 1, 3, 2'b01);
        step("ch3_released", 1, 4'b0000, 0, 0, -1);
`ifdef MUX_RR_ARB_HOLD_LIMIT_EN
        // all requesting, ack=1: 4 beats per tenure, rotation 0,1,2,3,0
        step("idle_before_rotate", 1, 4'b1111, 1, 0, -1);
        for (int t = 0; t < 5; t++) begin
            for (int b = 0; b < 4; b++)
                step("rotate_beat", 1, 4'b1111, 1, 1, t % 4);
            step("rotate_bubble", 1, (t == 4) ? 4'b0000 : 4'b1111, 1, 0, -1);
        end
        step("rotate_done", 1, 4'b0000, 0, 0, -1);
`else
        // no limit: ch0 keeps grant; toggling req[1] has no effect
        step("idle_before_hold", 1, 4'b0011, 1, 0, -1);
        for (int i = 0; i < 20; i++)
            step("nolimit_hold_ch0", 1, (i % 2 == 1) ? 4'b0011 : 4'b0001, 1, 1, 0);
        step("nolimit_drop_cycle", 1, 4'b0000, 1, 1, 0);
        step("nolimit_released", 1, 4'b0000, 0, 0, -1);
`endif
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
